// File: rtl/tdc_seq_pkg.sv
// Shared types and width helpers for the TDC measurement sequencer and its encoder.
package tdc_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StLaunch,
    StCapture,
    StAccum,
    StDone
  } tdc_state_e;

  localparam int unsigned TapsDefault       = 32;
  localparam int unsigned MaxAvgLog2Default = 7;
  localparam int unsigned AvgCfgW           = 3;
  localparam int unsigned SettleW           = 4;

  // Width of a popcount that can reach TAPS inclusive.
  function automatic int unsigned enc_width(input int unsigned taps);
    return $clog2(taps + 1);
  endfunction

  localparam int unsigned EncWDefault = enc_width(TapsDefault);
  localparam int unsigned AccWDefault = EncWDefault + MaxAvgLog2Default;

endpackage

// File: rtl/tdc_therm_encoder.sv
// Bubble-tolerant thermometer encoder: popcount plus bubble and all-ones detection.
module tdc_therm_encoder
  import tdc_seq_pkg::*;
#(
  parameter int unsigned TAPS = TapsDefault,
  localparam int unsigned ENC_W = enc_width(TAPS)
) (
  input  logic [TAPS-1:0]  therm_i,
  output logic [ENC_W-1:0] enc_o,
  output logic             bubble_o,
  output logic             ovf_o
);

  always_comb begin
    enc_o = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      enc_o = enc_o + ENC_W'(therm_i[i]);
    end
  end

  // A zero tap followed by a one tap means the code is not a clean thermometer.
  always_comb begin
    bubble_o = 1'b0;
    for (int unsigned i = 0; i < TAPS - 1; i++) begin
      if (!therm_i[i] && therm_i[i+1]) begin
        bubble_o = 1'b1;
      end
    end
  end

  assign ovf_o = &therm_i;

endmodule

// File: rtl/tdc_meas_sequencer.sv
// Measurement controller: runs 2^avg arm/launch/capture cycles on the TDC delay line,
// accumulates encoded samples and reports sum, mean and sticky error flags.
module tdc_meas_sequencer
  import tdc_seq_pkg::*;
#(
  parameter int unsigned TAPS         = TapsDefault,
  parameter int unsigned MAX_AVG_LOG2 = MaxAvgLog2Default,
  localparam int unsigned ENC_W = enc_width(TAPS),
  localparam int unsigned ACC_W = ENC_W + MAX_AVG_LOG2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ena_i,
  input  logic               start_i,
  input  logic [AvgCfgW-1:0] cfg_avg_log2_i,
  input  logic [SettleW-1:0] cfg_settle_i,
  output logic               tdc_arm_o,
  output logic               tdc_launch_o,
  output logic               tdc_capture_o,
  input  logic [TAPS-1:0]    tdc_therm_i,
  output logic               busy_o,
  output logic               result_valid_o,
  output logic [ACC_W-1:0]   result_sum_o,
  output logic [ENC_W-1:0]   result_mean_o,
  output logic               bubble_err_o,
  output logic               ovf_err_o
);

  localparam int unsigned SampW = MAX_AVG_LOG2;
  localparam logic [AvgCfgW-1:0] MaxAvg = AvgCfgW'(MAX_AVG_LOG2);
  localparam logic [SampW:0] SampOne = (SampW + 1)'(1);

  tdc_state_e state_q, state_d;

  logic [AvgCfgW-1:0] avg_q, avg_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic [SampW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [TAPS-1:0]    therm_q, therm_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               bub_acc_q, bub_acc_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [ENC_W-1:0]   mean_q, mean_d;
  logic               bubble_err_q, bubble_err_d;
  logic               ovf_err_q, ovf_err_d;

  logic               start_ok;
  logic [AvgCfgW-1:0] avg_clamped;
  logic               arm_done;
  logic               last_sample;
  logic [SampW:0]     n_samples;
  logic [SampW-1:0]   last_idx;
  logic [ENC_W-1:0]   enc;
  logic               enc_bubble;
  logic               enc_ovf;
  logic [ACC_W-1:0]   sum_next;

  tdc_therm_encoder #(
    .TAPS(TAPS)
  ) u_encoder (
    .therm_i  (therm_q),
    .enc_o    (enc),
    .bubble_o (enc_bubble),
    .ovf_o    (enc_ovf)
  );

  assign start_ok    = (state_q == StIdle) && start_i && ena_i;
  assign avg_clamped = (cfg_avg_log2_i > MaxAvg) ? MaxAvg : cfg_avg_log2_i;
  assign arm_done    = (settle_cnt_q == settle_q);
  assign n_samples   = SampOne << avg_q;
  assign last_idx    = SampW'(n_samples - SampOne);
  assign last_sample = (sample_cnt_q == last_idx);
  assign sum_next    = acc_q + ACC_W'(enc);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping ena aborts any measurement in flight
  always_comb begin
    state_d = state_q;
    if (!ena_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (start_i) state_d = StArm;
        StArm:     if (arm_done) state_d = StLaunch;
        StLaunch:  state_d = StCapture;
        StCapture: state_d = StAccum;
        StAccum:   state_d = last_sample ? StDone : StArm;
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Output decode
  always_comb begin
    tdc_arm_o      = 1'b0;
    tdc_launch_o   = 1'b0;
    tdc_capture_o  = 1'b0;
    result_valid_o = 1'b0;
    unique case (state_q)
      StArm: tdc_arm_o = 1'b1;
      StLaunch: begin
        tdc_arm_o    = 1'b1;
        tdc_launch_o = 1'b1;
      end
      StCapture: tdc_capture_o  = 1'b1;
      StDone:    result_valid_o = 1'b1;
      default: ;
    endcase
    busy_o = (state_q != StIdle);
  end

  // Datapath next-state: config latch, counters, capture, accumulate and publish
  always_comb begin
    avg_d        = avg_q;
    settle_d     = settle_q;
    settle_cnt_d = '0;
    sample_cnt_d = sample_cnt_q;
    therm_d      = therm_q;
    acc_d        = acc_q;
    bub_acc_d    = bub_acc_q;
    ovf_acc_d    = ovf_acc_q;
    sum_d        = sum_q;
    mean_d       = mean_q;
    bubble_err_d = bubble_err_q;
    ovf_err_d    = ovf_err_q;

    if (start_ok) begin
      avg_d        = avg_clamped;
      settle_d     = cfg_settle_i;
      sample_cnt_d = '0;
      acc_d        = '0;
      bub_acc_d    = 1'b0;
      ovf_acc_d    = 1'b0;
    end

    if (ena_i) begin
      if (state_q == StArm && !arm_done) begin
        settle_cnt_d = settle_cnt_q + 1'b1;
      end
      if (state_q == StCapture) begin
        therm_d = tdc_therm_i;
      end
      if (state_q == StAccum) begin
        acc_d     = sum_next;
        bub_acc_d = bub_acc_q | enc_bubble;
        ovf_acc_d = ovf_acc_q | enc_ovf;
        if (last_sample) begin
          sum_d        = sum_next;
          mean_d       = ENC_W'(sum_next >> avg_q);
          bubble_err_d = bub_acc_q | enc_bubble;
          ovf_err_d    = ovf_acc_q | enc_ovf;
        end else begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      avg_q        <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      therm_q      <= '0;
      acc_q        <= '0;
      bub_acc_q    <= 1'b0;
      ovf_acc_q    <= 1'b0;
      sum_q        <= '0;
      mean_q       <= '0;
      bubble_err_q <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      avg_q        <= avg_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      therm_q      <= therm_d;
      acc_q        <= acc_d;
      bub_acc_q    <= bub_acc_d;
      ovf_acc_q    <= ovf_acc_d;
      sum_q        <= sum_d;
      mean_q       <= mean_d;
      bubble_err_q <= bubble_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign result_sum_o  = sum_q;
  assign result_mean_o = mean_q;
  assign bubble_err_o  = bubble_err_q;
  assign ovf_err_o     = ovf_err_q;

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Randomized self-checking bench for tdc_meas_sequencer against a per-measurement arithmetic model.
module tb_tdc_meas_sequencer;

  localparam int unsigned Taps = 32;
  localparam int unsigned EncW = 6;
  localparam int unsigned AccW = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic            start;
  logic [2:0]      cfg_avg;
  logic [3:0]      cfg_settle;
  logic [Taps-1:0] therm;
  logic            arm, launch, capture, busy, valid, bub, ovf;
  logic [AccW-1:0] sum;
  logic [EncW-1:0] mean;

  int checks   = 0;
  int failures = 0;

  logic [31:0] samp [128];
  longint      last_sum, last_mean;
  longint      last_bub, last_ovf;

  always #5 clk = ~clk;

  tdc_meas_sequencer #(
    .TAPS         (Taps),
    .MAX_AVG_LOG2 (7)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ena_i          (ena),
    .start_i        (start),
    .cfg_avg_log2_i (cfg_avg),
    .cfg_settle_i   (cfg_settle),
    .tdc_arm_o      (arm),
    .tdc_launch_o   (launch),
    .tdc_capture_o  (capture),
    .tdc_therm_i    (therm),
    .busy_o         (busy),
    .result_valid_o (valid),
    .result_sum_o   (sum),
    .result_mean_o  (mean),
    .bubble_err_o   (bub),
    .ovf_err_o      (ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input longint exp);
    checks++;
    if (obs !== 64'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A clean thermometer code x satisfies x & (x+1) == 0.
  function automatic bit is_bubbly(input logic [31:0] t);
    logic [63:0] w;
    w = 64'(t);
    return (w & (w + 64'd1)) != 64'd0;
  endfunction

  function automatic logic [31:0] rand_therm();
    int          k;
    logic [63:0] t;
    k = int'($urandom_range(0, 32));
    t = (64'd1 << k) - 64'd1;
    case ($urandom_range(0, 4))
      0, 1: ;
      2: t = 64'($urandom);
      3: t = 64'hFFFF_FFFF;
      default: t[$urandom_range(0, 31)] ^= 1'b1;
    endcase
    return t[31:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_arm"}, arm, 0);
    check_eq({tag, "_launch"}, launch, 0);
    check_eq({tag, "_capture"}, capture, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_valid"}, valid, 0);
    check_eq({tag, "_sum"}, sum, 0);
    check_eq({tag, "_mean"}, mean, 0);
    check_eq({tag, "_bub"}, bub, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
  endtask

  // mode 0: plain run; 1: extra start pulse at mode_cyc; 2: ena low at mode_cyc;
  // 3: rst at the first capture. Cycle 1 is the first cycle after start acceptance.
  task automatic run_meas(input int avg, input int settle, input int mode, input int mode_cyc);
    int     avg_c, n, per, exp_done, limit;
    int     launches, valids, done_c, first_l, prev_l;
    bit     stop, rst_done;
    longint exp_sum, exp_mean, exp_bub, exp_ovf;

    avg_c    = (avg > 7) ? 7 : avg;
    n        = 1 << avg_c;
    per      = settle + 4;
    exp_done = 1 + n * per;
    limit    = exp_done + 6;
    exp_sum  = 0;
    exp_bub  = 0;
    exp_ovf  = 0;
    for (int j = 0; j < n; j++) begin
      exp_sum += longint'($countones(samp[j]));
      if (is_bubbly(samp[j])) exp_bub = 1;
      if (samp[j] == 32'hFFFF_FFFF) exp_ovf = 1;
    end
    exp_mean = exp_sum >> avg_c;

    launches = 0;
    valids   = 0;
    done_c   = -1;
    first_l  = -1;
    prev_l   = 0;
    stop     = 0;
    rst_done = 0;

    @(negedge clk);
    cfg_avg    = 3'(avg);
    cfg_settle = 4'(settle);
    start      = 1'b1;

    for (int c = 1; c <= limit && !stop; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start      = 1'b0;
        cfg_avg    = 3'($urandom);
        cfg_settle = 4'($urandom);
        check_eq("busy_after_start", busy, 1);
      end
      if (mode == 1) start = (c == mode_cyc);
      if (launch) begin
        if (launches == 0) first_l = c;
        else check_eq("launch_spacing", 64'(c - prev_l), per);
        prev_l = c;
        if (launches < 128) therm = samp[launches];
        launches++;
      end
      if (valid) begin
        valids++;
        done_c = c;
        check_eq("done_sum", sum, exp_sum);
        check_eq("done_mean", mean, exp_mean);
        check_eq("done_bubble", bub, exp_bub);
        check_eq("done_ovf", ovf, exp_ovf);
        check_eq("done_busy", busy, 1);
      end
      if (done_c > 0 && c == done_c + 1) begin
        check_eq("post_busy", busy, 0);
        check_eq("post_valid", valid, 0);
        check_eq("post_sum_hold", sum, exp_sum);
        check_eq("post_mean_hold", mean, exp_mean);
      end
      if (mode == 2) begin
        if (c == mode_cyc) begin
          ena = 1'b0;
        end else if (c == mode_cyc + 1) begin
          ena = 1'b1;
          check_eq("abort_busy", busy, 0);
          check_eq("abort_arm", arm, 0);
          check_eq("abort_launch", launch, 0);
          check_eq("abort_capture", capture, 0);
        end
      end
      if (mode == 3) begin
        if (rst_done) begin
          check_all_zero("rst_mid");
          rst  = 1'b0;
          stop = 1;
        end else if (capture) begin
          rst      = 1'b1;
          rst_done = 1;
        end
      end
    end
    start = 1'b0;

    if (mode == 0 || mode == 1) begin
      check_eq("valid_count", valids, 1);
      check_eq("done_cycle", done_c, exp_done);
      check_eq("launch_count", launches, n);
      check_eq("first_launch", first_l, settle + 2);
      last_sum  = exp_sum;
      last_mean = exp_mean;
      last_bub  = exp_bub;
      last_ovf  = exp_ovf;
    end else if (mode == 2) begin
      check_eq("abort_no_valid", valids, 0);
      check_eq("abort_sum_kept", sum, last_sum);
      check_eq("abort_mean_kept", mean, last_mean);
      check_eq("abort_bub_kept", bub, last_bub);
      check_eq("abort_ovf_kept", ovf, last_ovf);
    end else begin
      check_eq("rst_seen_capture", rst_done, 1);
      last_sum  = 0;
      last_mean = 0;
      last_bub  = 0;
      last_ovf  = 0;
    end
  endtask

  initial begin
    int avg, settle, mode, mcyc, edone;

    rst        = 1'b1;
    ena        = 1'b1;
    start      = 1'b0;
    cfg_avg    = '0;
    cfg_settle = '0;
    therm      = '0;
    last_sum   = 0;
    last_mean  = 0;
    last_bub   = 0;
    last_ovf   = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // start coincident with rst is dropped
    start = 1'b1;
    @(negedge clk);
    check_eq("rst_beats_start", busy, 0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    samp[0] = 32'h0000_FFFF;
    run_meas(0, 0, 0, 0);

    for (int j = 0; j < 4; j++) samp[j] = 32'h00FF_FFFF;
    run_meas(2, 3, 0, 0);

    samp[0] = 32'h0000_F0FF;
    samp[1] = 32'h0000_000F;
    run_meas(1, 2, 0, 0);

    samp[0] = 32'hFFFF_FFFF;
    run_meas(0, 1, 0, 0);
    samp[0] = 32'h0000_00FF;
    run_meas(0, 0, 0, 0);

    for (int j = 0; j < 8; j++) samp[j] = rand_therm();
    run_meas(3, 1, 1, 6);

    for (int j = 0; j < 8; j++) samp[j] = rand_therm();
    run_meas(3, 2, 2, 1 + 2 * (2 + 4));

    for (int j = 0; j < 4; j++) samp[j] = rand_therm();
    run_meas(2, 0, 3, 0);

    for (int j = 0; j < 128; j++) samp[j] = 32'h0000_0001;
    run_meas(7, 0, 0, 0);

    for (int r = 0; r < 30; r++) begin
      avg    = int'($urandom_range(0, 4));
      settle = int'($urandom_range(0, 15));
      mode   = int'($urandom_range(0, 2));
      edone  = 1 + (1 << avg) * (settle + 4);
      mcyc   = int'($urandom_range(2, edone - 1));
      for (int j = 0; j < 16; j++) samp[j] = rand_therm();
      run_meas(avg, settle, mode, mcyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
